// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads imem over req/ack and queues up to two words for decode.
// A word reaches decode the cycle after its ack; redirect flushes the queue and drops in-flight data.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic [1:0]  r_cnt;
  logic [31:0] r_q0_inst, r_q0_pc, r_q1_inst, r_q1_pc;

  logic        w_ack, w_pop, w_push, w_issue, w_unused;
  logic [31:0] w_redir_pc;

  assign w_ack      = r_req & imem_ack;
  assign w_pop      = (r_cnt != 2'd0) & dec_ready & ~redirect;
  assign w_push     = (r_state == S_WAIT) & w_ack & ~redirect;
  assign w_issue    = (r_cnt != 2'd2) | w_pop;
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_unused   = ^redirect_pc[1:0];

  // A redirect seen in FETCH issues straight to the new target so it goes out next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (redirect) begin
            r_pc    <= w_redir_pc;
            r_addr  <= w_redir_pc;
            r_req   <= 1'b1;
            r_state <= S_WAIT;
          end else if (w_issue) begin
            r_addr  <= r_pc;
            r_req   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            r_pc <= w_redir_pc;
            if (w_ack) begin
              r_req   <= 1'b0;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_DROP;
            end
          end else if (w_ack) begin
            r_pc    <= r_pc + 32'd4;
            r_req   <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_DROP: begin
          if (redirect) r_pc <= w_redir_pc;
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  // Two-entry queue with entry 0 as head; a flush only clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 2'd0;
      r_q0_inst <= 32'd0;
      r_q0_pc   <= 32'd0;
      r_q1_inst <= 32'd0;
      r_q1_pc   <= 32'd0;
    end else if (redirect) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_q0_inst <= imem_rdata;
            r_q0_pc   <= r_addr;
          end else begin
            r_q1_inst <= imem_rdata;
            r_q1_pc   <= r_addr;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0_inst <= r_q1_inst;
          r_q0_pc   <= r_q1_pc;
          r_cnt     <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0_inst <= imem_rdata;
            r_q0_pc   <= r_addr;
          end else begin
            r_q0_inst <= r_q1_inst;
            r_q0_pc   <= r_q1_pc;
            r_q1_inst <= imem_rdata;
            r_q1_pc   <= r_addr;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign dec_valid = (r_cnt != 2'd0);
  assign dec_inst  = r_q0_inst;
  assign dec_pc    = r_q0_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, checked against an
// expected instruction stream (sequential PCs restarted at each redirect or reset).
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  int          cyc      = 0;
  int          last_pop = -1;
  int          wait_cnt = 0;
  int          ack_delay = 0;
  bit          rand_delay = 0;
  bit          cad_on   = 0;
  logic [31:0] exp_pc   = RST_PC;
  bit          p_req = 0, p_ack = 0, p_rst = 1, p_hold = 0, p_redir = 0;
  logic [31:0] p_addr, p_pc, p_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory responds, model consumes, then protocol checks on the next cycle.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
    bit ack;
    if (!p_rst) begin
      if (p_req && !p_ack) begin
        chk("req_held", {31'd0, imem_req}, 32'd1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (p_redir) chk("valid_after_redirect", {31'd0, dec_valid}, 32'd0);
      if (p_hold) begin
        chk("hold_valid", {31'd0, dec_valid}, 32'd1);
        chk("hold_pc", dec_pc, p_pc);
        chk("hold_inst", dec_inst, p_inst);
      end
    end
    if (rand_delay && imem_req && !p_req) ack_delay = $urandom_range(0, 3);
    ack = imem_req && (wait_cnt >= ack_delay);
    imem_ack    = ack;
    imem_rdata  = ack ? mem(imem_addr) : 32'hDEAD_BEEF;
    dec_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (!rst) begin
      if (dec_valid && rdy && !redir) begin
        chk("pop_pc", dec_pc, exp_pc);
        chk("pop_inst", dec_inst, mem(exp_pc));
        if (cad_on && last_pop >= 0) chk("cadence", cyc - last_pop, 2);
        last_pop = cyc;
        exp_pc   = exp_pc + 32'd4;
        n_pops++;
      end
      if (redir) exp_pc = {rpc[31:2], 2'b00};
    end
    p_req   = imem_req;
    p_ack   = ack;
    p_addr  = imem_addr;
    p_rst   = rst;
    p_hold  = dec_valid && !rdy && !redir && !rst;
    p_redir = redir && !rst;
    p_pc    = dec_pc;
    p_inst  = dec_inst;
    @(posedge clk);
    #1;
    cyc++;
    if (p_rst) begin
      exp_pc   = RST_PC;
      wait_cnt = 0;
    end else if (!p_req || p_ack) begin
      wait_cnt = 0;
    end else begin
      wait_cnt++;
    end
  endtask

  task automatic wait_req(input bit lvl, input string tag);
    int k = 0;
    while (imem_req !== lvl && k < 40) begin
      step(1'b1, 1'b0, 32'd0);
      k++;
    end
    chk(tag, {31'd0, imem_req}, {31'd0, lvl});
  endtask

  task automatic wait_pops(input int n, input string tag);
    int target = n_pops + n;
    int k = 0;
    while (n_pops < target && k < 60) begin
      step(1'b1, 1'b0, 32'd0);
      k++;
    end
    chk(tag, n_pops, target);
  endtask

  initial begin
    logic [31:0] a;
    int k;
    int pops0;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_inst", dec_inst, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    rst = 1'b0;

    // Zero-wait streaming from the reset PC at one word per two cycles.
    k = 0;
    while (imem_req !== 1'b1 && k < 2) begin step(1'b1, 1'b0, 32'd0); k++; end
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);
    cad_on = 1; last_pop = -1;
    wait_pops(4, "stream_pops");
    cad_on = 0;

    // Decode stalled: queue fills to two words and fetch stops.
    repeat (10) step(1'b0, 1'b0, 32'd0);
    chk("full_valid", {31'd0, dec_valid}, 32'd1);
    chk("full_no_req", {31'd0, imem_req}, 32'd0);
    chk("full_head_pc", dec_pc, exp_pc);
    chk("full_head_inst", dec_inst, mem(exp_pc));
    ack_delay = 1000;
    step(1'b1, 1'b0, 32'd0);
    chk("second_word_valid", {31'd0, dec_valid}, 32'd1);
    step(1'b1, 1'b0, 32'd0);
    chk("drained_valid", {31'd0, dec_valid}, 32'd0);
    ack_delay = 0;

    // Three-cycle ack delay.
    wait_req(1'b0, "idle_before_slow");
    ack_delay = 3;
    wait_req(1'b1, "slow_req");
    a = imem_addr;
    for (int i = 0; i < 4; i++) begin
      chk("slow_req_held", {31'd0, imem_req}, 32'd1);
      chk("slow_addr_held", imem_addr, a);
      step(1'b1, 1'b0, 32'd0);
    end
    chk("slow_word_valid", {31'd0, dec_valid}, 32'd1);
    chk("slow_word_pc", dec_pc, a);

    // Redirect with a request outstanding and no ack yet.
    ack_delay = 1000;
    wait_req(1'b1, "pre_redirect_req");
    a = imem_addr;
    step(1'b1, 1'b1, 32'h0000_1003);
    chk("drop_req_held", {31'd0, imem_req}, 32'd1);
    chk("drop_old_addr", imem_addr, a);
    ack_delay = 2;
    wait_req(1'b0, "drop_ack_done");
    ack_delay = 0;
    wait_req(1'b1, "post_drop_req");
    chk("post_drop_addr", imem_addr, 32'h0000_1000);
    wait_pops(2, "post_drop_pops");

    // Redirect coinciding with an ack and a pop.
    step(1'b1, 1'b1, 32'h0000_3000);
    k = 0;
    while (dec_valid !== 1'b1 && k < 20) begin step(1'b0, 1'b0, 32'd0); k++; end
    chk("setup_valid", {31'd0, dec_valid}, 32'd1);
    ack_delay = 1000;
    step(1'b0, 1'b0, 32'd0);
    chk("setup_req", {31'd0, imem_req}, 32'd1);
    chk("setup_still_valid", {31'd0, dec_valid}, 32'd1);
    ack_delay = 0;
    step(1'b1, 1'b1, 32'h0000_2000);
    chk("coinc_req_low", {31'd0, imem_req}, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("coinc_new_req", {31'd0, imem_req}, 32'd1);
    chk("coinc_new_addr", imem_addr, 32'h0000_2000);
    wait_pops(2, "coinc_pops");

    // Redirect from idle, then PC wrap at the top of the address space.
    wait_req(1'b0, "idle_before_wrap");
    step(1'b1, 1'b1, 32'hFFFF_FFFE);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_req(1'b0, "wrap_ack_done");
    wait_req(1'b1, "wrap_next_req");
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);
    wait_pops(2, "wrap_pops");

    // Reset while a request is outstanding.
    ack_delay = 1000;
    wait_req(1'b1, "pre_reset_req");
    rst = 1'b1;
    step(1'b1, 1'b0, 32'd0);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr, RST_PC);
    chk("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("mid_rst_inst", dec_inst, 32'd0);
    chk("mid_rst_pc", dec_pc, 32'd0);
    rst = 1'b0;
    ack_delay = 0;
    wait_pops(2, "post_reset_pops");

    // Random traffic: variable memory latency, decode stalls and redirects.
    rand_delay = 1;
    pops0 = n_pops;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom);
    end
    chk("random_progress", {31'd0, (n_pops - pops0) > 50}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
